// File: rtl/spad_pkg.sv
// Shared types and helpers for the accumulating PE scratchpad.
package spad_pkg;

    localparam int unsigned SPAD_DATA_WIDTH    = 16;
    localparam int unsigned SPAD_ADDR_BITWIDTH = 9;

    typedef enum logic {
        WM_OVERWRITE = 1'b0,
        WM_ACCUM     = 1'b1
    } wmode_e;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

    // Largest signed value of a dw-bit word, zero-extended to 64 bits.
    function automatic logic [63:0] sat_max(input int unsigned dw);
        return (64'd1 << (dw - 1)) - 64'd1;
    endfunction

    // Most negative signed dw-bit word; only the low dw bits are meaningful.
    function automatic logic [63:0] sat_min(input int unsigned dw);
        return ~sat_max(dw);
    endfunction

endpackage

// File: rtl/spad_sat_add.sv
// Signed adder with optional clamping to the signed range; flags overflow.
module spad_sat_add
    import spad_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SPAD_DATA_WIDTH,
    parameter bit          SATURATE   = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum_c,
    output logic                  ovf_c
);

    localparam logic [DATA_WIDTH-1:0] SMAX = DATA_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SMIN = DATA_WIDTH'(sat_min(DATA_WIDTH));

    logic [DATA_WIDTH:0] wide;

    // One guard bit: overflow when the guard and the sign disagree.
    always_comb begin
        wide  = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        ovf_c = wide[DATA_WIDTH] ^ wide[DATA_WIDTH-1];
        sum_c = wide[DATA_WIDTH-1:0];
        if (ovf_c && SATURATE) begin
            sum_c = wide[DATA_WIDTH] ? SMIN : SMAX;
        end
    end

endmodule

// File: rtl/spad_acc.sv
// PE-local psum scratchpad: 2-stage overwrite/accumulate write pipeline with
// forwarding, latency-1 read, sticky overflow flag and a bulk-clear engine.
module spad_acc
    import spad_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = SPAD_DATA_WIDTH,
    parameter int unsigned ADDR_BITWIDTH = SPAD_ADDR_BITWIDTH,
    parameter int unsigned DEPTH         = 1 << ADDR_BITWIDTH,
    parameter bit          SATURATE      = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_clear,
    output logic                     o_busy,
    input  logic                     i_ren,
    input  logic [ADDR_BITWIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata,
    output logic                     o_rvalid,
    input  logic                     i_wen,
    input  logic [ADDR_BITWIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic                     i_wmode,
    output logic                     o_ovf,
    input  logic                     i_ovf_clr
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned AW1   = ADDR_BITWIDTH + 1;
    localparam logic [ADDR_BITWIDTH:0]   DEPTH_W   = AW1'(DEPTH);
    localparam logic [ADDR_BITWIDTH-1:0] LAST_ADDR = ADDR_BITWIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    clr_state_e               state_q;
    clr_state_e               state_d;
    logic [ADDR_BITWIDTH-1:0] clr_cnt_q;
    logic                     busy_q;
    logic                     idle_c;
    logic                     clr_we_c;
    logic                     clear_go_c;

    logic                     s2_valid_q;
    logic [ADDR_BITWIDTH-1:0] s2_addr_q;
    logic [DATA_WIDTH-1:0]    s2_data_q;
    logic [DATA_WIDTH-1:0]    s2_old_q;
    wmode_e                   s2_mode_q;

    logic [DATA_WIDTH-1:0]    sum_c;
    logic                     add_ovf_c;
    logic [DATA_WIDTH-1:0]    s2_result_c;
    logic                     s2_ovf_c;
    logic                     w_accept_c;
    logic                     r_accept_c;
    logic [DATA_WIDTH-1:0]    w_old_c;
    logic [DATA_WIDTH-1:0]    r_word_c;

    // Clear FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_IDLE: if (i_clear) state_d = CLR_RUN;
            CLR_RUN:  if (clr_cnt_q == LAST_ADDR) state_d = CLR_IDLE;
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        idle_c   = 1'b0;
        clr_we_c = 1'b0;
        case (state_q)
            CLR_IDLE: idle_c   = 1'b1;
            CLR_RUN:  clr_we_c = 1'b1;
        endcase
    end

    assign clear_go_c = idle_c && i_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            busy_q <= (state_d == CLR_RUN);
            if (clr_we_c) begin
                clr_cnt_q <= (clr_cnt_q == LAST_ADDR) ? '0 : clr_cnt_q + 1'b1;
            end else if (clear_go_c) begin
                clr_cnt_q <= '0;
            end
        end
    end

    assign o_busy = busy_q;

    spad_sat_add #(
        .DATA_WIDTH (DATA_WIDTH),
        .SATURATE   (SATURATE)
    ) u_sat_add (
        .a     (s2_old_q),
        .b     (s2_data_q),
        .sum_c (sum_c),
        .ovf_c (add_ovf_c)
    );

    // S2 result, plus forwarding of that result into S1 and the read port
    always_comb begin
        s2_result_c = (s2_mode_q == WM_ACCUM) ? sum_c : s2_data_q;
        s2_ovf_c    = s2_valid_q && (s2_mode_q == WM_ACCUM) && add_ovf_c;
        w_accept_c  = i_wen && idle_c && !i_clear && ({1'b0, i_waddr} < DEPTH_W);
        r_accept_c  = i_ren && idle_c;
        w_old_c     = (s2_valid_q && s2_addr_q == i_waddr) ? s2_result_c
                                                           : mem[IDX_W'(i_waddr)];
        r_word_c    = '0;
        if ({1'b0, i_raddr} < DEPTH_W) begin
            r_word_c = (s2_valid_q && s2_addr_q == i_raddr) ? s2_result_c
                                                            : mem[IDX_W'(i_raddr)];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
            s2_old_q   <= '0;
            s2_mode_q  <= WM_OVERWRITE;
            o_rdata    <= '0;
            o_rvalid   <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            s2_valid_q <= w_accept_c;
            if (w_accept_c) begin
                s2_addr_q <= i_waddr;
                s2_data_q <= i_wdata;
                s2_old_q  <= w_old_c;
                s2_mode_q <= wmode_e'(i_wmode);
            end
            o_rvalid <= r_accept_c;
            o_rdata  <= r_accept_c ? r_word_c : '0;
            if (s2_ovf_c) begin
                o_ovf <= 1'b1;
            end else if (i_ovf_clr) begin
                o_ovf <= 1'b0;
            end
        end
    end

    // Single write port: the clear engine and S2 never overlap
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem[IDX_W'(clr_cnt_q)] <= '0;
        end else if (s2_valid_q) begin
            mem[IDX_W'(s2_addr_q)] <= s2_result_c;
        end
    end

endmodule
